// File: rtl/tinyriscv_pkg.sv
// Shared decode constants and enums for the RV32M multiply/divide unit.
package tinyriscv_pkg;

    localparam logic [6:0] OpcodeOp     = 7'b0110011;
    localparam logic [6:0] Funct7MulDiv = 7'b0000001;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: passes data through or negates it.
module muldiv_negate #(
    parameter int unsigned Width = 32
) (
    input  logic             neg_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    assign data_o = neg_i ? (~data_i + Width'(1)) : data_i;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Define EX_MULDIV_FAST_MUL_EN to complete multiplies in one cycle from a single product.
module ex_muldiv
    import tinyriscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            reg_we_o,
    output logic [4:0]      reg_waddr_o
);

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;

    muldiv_op_e      op_in;
    logic            sign1, sign2, neg_start, div0, ovf;
    logic [XLEN-1:0] mag1, mag2, shortcut_val;

    assign op_in = muldiv_op_e'(op_i);

    always_comb begin
        sign1 = op1_i[XLEN-1] & (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem});
        sign2 = op2_i[XLEN-1] & (op_in inside {OpMulh, OpDiv, OpRem});
        unique case (op_in)
            OpMulh, OpMulhsu, OpDiv: neg_start = sign1 ^ sign2;
            OpRem:                   neg_start = sign1;
            default:                 neg_start = 1'b0;
        endcase
        div0 = op_i[2] & (op2_i == '0);
        ovf  = (op_in inside {OpDiv, OpRem}) & (op1_i == IntMin) & (op2_i == '1);
        if (div0) begin
            shortcut_val = op_i[1] ? op1_i : '1;
        end else begin
            shortcut_val = op_i[1] ? '0 : IntMin;
        end
    end

    muldiv_negate #(.Width(XLEN)) u_neg_op1 (.neg_i(sign1), .data_i(op1_i), .data_o(mag1));
    muldiv_negate #(.Width(XLEN)) u_neg_op2 (.neg_i(sign2), .data_i(op2_i), .data_o(mag2));

    // Shared datapath: {a,b} is the 64-bit product for multiply, {remainder,quotient} for divide.
    logic [XLEN:0]   mul_sum, div_diff;
    logic [XLEN-1:0] mul_addend, a_step, b_step;
    logic            div_ge;

    always_comb begin
        mul_addend = b_q[0] ? d_q : '0;
        mul_sum    = {1'b0, a_q} + {1'b0, mul_addend};
        div_diff   = {a_q, b_q[XLEN-1]} - {1'b0, d_q};
        div_ge     = ~div_diff[XLEN];
        if (op_q[2]) begin
            a_step = div_ge ? div_diff[XLEN-1:0] : {a_q[XLEN-2:0], b_q[XLEN-1]};
            b_step = {b_q[XLEN-2:0], div_ge};
        end else begin
            a_step = mul_sum[XLEN:1];
            b_step = {mul_sum[0], b_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] fin_raw, fin_res;
    logic              fin_neg;
    logic [2:0]        fin_op;
    logic [XLEN-1:0]   fin_word;

    always_comb begin
        fin_neg = neg_q;
        fin_op  = op_q;
        if (op_q[2]) begin
            fin_raw = {{XLEN{1'b0}}, (op_q[1] ? a_step : b_step)};
        end else begin
            fin_raw = {a_step, b_step};
        end
`ifdef EX_MULDIV_FAST_MUL_EN
        if (state_q == StIdle) begin
            fin_raw = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
            fin_neg = neg_start;
            fin_op  = op_i;
        end
`endif
    end

    muldiv_negate #(.Width(2*XLEN)) u_neg_res (.neg_i(fin_neg), .data_i(fin_raw), .data_o(fin_res));

    assign fin_word = (fin_op == OpMul || fin_op[2]) ? fin_res[XLEN-1:0]
                                                      : fin_res[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        waddr_d  = waddr_q;
        result_d = result_q;
        rd_d     = rd_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    neg_d   = neg_start;
                    cnt_d   = '0;
                    waddr_d = reg_waddr_i;
                    a_d     = '0;
                    b_d     = op_i[2] ? mag1 : mag2;
                    d_d     = op_i[2] ? mag2 : mag1;
                    if (div0 || ovf) begin
                        state_d  = StDone;
                        result_d = shortcut_val;
                        rd_d     = reg_waddr_i;
`ifdef EX_MULDIV_FAST_MUL_EN
                    end else if (!op_i[2]) begin
                        state_d  = StDone;
                        result_d = fin_word;
                        rd_d     = reg_waddr_i;
`endif
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                a_d   = a_step;
                b_d   = b_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = StDone;
                    result_d = fin_word;
                    rd_d     = waddr_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            waddr_q  <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            waddr_q  <= waddr_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign busy_o      = ((state_q == StIdle) & start_i & ~flush_i) | (state_q == StCalc);
    assign valid_o     = (state_q == StDone) & ~flush_i;
    assign reg_we_o    = valid_o;
    assign result_o    = result_q;
    assign reg_waddr_o = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv with hand-computed results and latencies.
module tb_ex_muldiv;

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o, valid_o, reg_we_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv #(.XLEN(32)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .op_i        (op_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; start is accepted at the next posedge (cycle T).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int cycles;
        int busy_bad;
        op_i        = op;
        op1_i       = a;
        op2_i       = b;
        reg_waddr_i = rd;
        start_i     = 1'b1;
        #1;
        busy_bad = busy_o ? 0 : 1;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        op1_i       = '0;
        op2_i       = '0;
        reg_waddr_i = '0;
        cycles      = 1;
        while (!valid_o && cycles < 100) begin
            if (!busy_o) busy_bad++;
            @(posedge clk_i);
            #1;
            cycles++;
        end
        if (busy_o) busy_bad++;
        check({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_rd"}, {27'd0, reg_waddr_o}, {27'd0, rd});
        check({tag, "_we"}, {31'd0, reg_we_o}, 32'd1);
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        @(posedge clk_i);
        #1;
        check({tag, "_idle"}, {30'd0, valid_o, busy_o}, 32'd0);
        check({tag, "_hold"}, result_o, exp_res);
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        op_i        = '0;
        op1_i       = '0;
        op2_i       = '0;
        reg_waddr_i = '0;
        flush_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ctrl", {29'd0, busy_o, valid_o, reg_we_o}, 32'd0);
        check("rst_res", result_o, 32'd0);
        check("rst_rd", {27'd0, reg_waddr_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd5, 32'd14, DivLat);
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd6, 32'd2, DivLat);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, DivLat);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, DivLat);
        run_op("div_nn", 3'd4, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd9, 32'd14, DivLat);
        run_op("rem_nn", 3'd6, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFFE, DivLat);
        run_op("divu_max", 3'd5, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'hFFFF_FFFF, DivLat);
        run_op("div_z", 3'd4, 32'd12345, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
        run_op("divu_z", 3'd5, 32'd7, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
        run_op("rem_z", 3'd6, 32'd5, 32'd0, 5'd14, 32'd5, 1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000, MulLat);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFF, MulLat);
        run_op("mul_neg", 3'd0, 32'd3, 32'hFFFF_FFFE, 5'd19, 32'hFFFF_FFFA, MulLat);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, MulLat);
        run_op("mul_lo", 3'd0, 32'h1234_5678, 32'h10, 5'd21, 32'h2345_6780, MulLat);

        // Flush at T+10 of a DIV: no valid, idle at T+11, fresh start completes.
        op_i        = 3'd4;
        op1_i       = 32'd1000;
        op2_i       = 32'd3;
        reg_waddr_i = 5'd22;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (9) begin
            @(posedge clk_i);
            #1;
        end
        flush_i = 1'b1;
        #1;
        check("flush_nov", {31'd0, valid_o}, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        #1;
        check("flush_idle", {30'd0, busy_o, valid_o}, 32'd0);
        run_op("post_flush", 3'd5, 32'd1000, 32'd3, 5'd23, 32'd333, DivLat);

        // start_i during CALC is ignored; the original DIVU result still appears.
        op_i        = 3'd5;
        op1_i       = 32'd100;
        op2_i       = 32'd7;
        reg_waddr_i = 5'd24;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) begin
            @(posedge clk_i);
            #1;
        end
        op_i        = 3'd4;
        op1_i       = 32'd9;
        op2_i       = 32'd0;
        reg_waddr_i = 5'd25;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        begin
            int cycles = 6;
            while (!valid_o && cycles < 100) begin
                @(posedge clk_i);
                #1;
                cycles++;
            end
            check("ign_lat", 32'(cycles), 32'd33);
        end
        check("ign_res", result_o, 32'd14);
        check("ign_rd", {27'd0, reg_waddr_o}, 32'd24);
        @(posedge clk_i);
        #1;

        // Reset in the middle of CALC clears every output on the next cycle.
        op_i        = 3'd5;
        op1_i       = 32'd50;
        op2_i       = 32'd4;
        reg_waddr_i = 5'd26;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (5) begin
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("mrst_ctrl", {29'd0, busy_o, valid_o, reg_we_o}, 32'd0);
        check("mrst_res", result_o, 32'd0);
        check("mrst_rd", {27'd0, reg_waddr_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_op("post_rst", 3'd7, 32'd50, 32'd4, 5'd27, 32'd2, DivLat);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
